l1_dcache_ctrl: RTL

//  CPU-side responder for the pipeline's MEM-stage data port: direct-mapped, write-back, write-allocate L1 data cache.

---
 rtl/l1_dcache_ctrl_pkg.sv | 28 ++
 rtl/dcache_line_store.sv | 62 ++++++
 rtl/l1_dcache_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared definitions for the L1 data cache controller: FSM encodings,
// default geometry and address-field width helpers.
package l1_dcache_ctrl_pkg;

  localparam int DEF_LINES  = 16;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2
  } dc_state_e;

  function automatic int off_width(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_width(input int lines);
    return $clog2(lines);
  endfunction

  // Tag is whatever remains above index, word offset and the byte lanes
  function automatic int tag_width(input int addr_w, input int lines, input int words);
    return addr_w - $clog2(lines) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays of the direct-mapped cache: two async read
// ports (CPU lookup, memory side) and one synchronous word/meta write port.
module dcache_line_store #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int TAG_W = 24,
  localparam int IDX_W = $clog2(LINES),
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [OFF_W-1:0] lk_offset,
  output logic [31:0]      lk_data,
  output logic [TAG_W-1:0] lk_tag,
  output logic             lk_valid,
  output logic             lk_dirty,
  input  logic [IDX_W-1:0] mx_index,
  input  logic [OFF_W-1:0] mx_offset,
  output logic [31:0]      mx_data,
  output logic [TAG_W-1:0] mx_tag,
  input  logic             wr_en,
  input  logic             wr_dirty,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [OFF_W-1:0] wr_offset,
  input  logic [31:0]      wr_data,
  input  logic             meta_en,
  input  logic [TAG_W-1:0] meta_tag
);

  logic [31:0]      data_r [LINES][WORDS];
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [LINES-1:0] valid_r;
  logic [LINES-1:0] dirty_r;

  // Data and tag arrays carry no reset; valid gates every use of them
  always_ff @(posedge clock) begin
    if (wr_en) data_r[wr_index][wr_offset] <= wr_data;
    if (meta_en) tag_r[wr_index] <= meta_tag;
  end

  // Line metadata: install clears dirty, a CPU store sets it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (meta_en) begin
      valid_r[wr_index] <= 1'b1;
      dirty_r[wr_index] <= 1'b0;
    end else if (wr_en && wr_dirty) begin
      dirty_r[wr_index] <= 1'b1;
    end
  end

  assign lk_data  = data_r[lk_index][lk_offset];
  assign lk_tag   = tag_r[lk_index];
  assign lk_valid = valid_r[lk_index];
  assign lk_dirty = dirty_r[lk_index];
  assign mx_data  = data_r[mx_index][mx_offset];
  assign mx_tag   = tag_r[mx_index];

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 D-cache controller with a
// word-serial refill/evict bus. Define DCACHE_STATS_EN for hit/miss/wback counters.
module l1_dcache_ctrl
  import l1_dcache_ctrl_pkg::*;
#(
  parameter int LINES  = DEF_LINES,
  parameter int WORDS  = DEF_WORDS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
`endif
);

  localparam int OFF_W = off_width(WORDS);
  localparam int IDX_W = idx_width(LINES);
  localparam int TAG_W = tag_width(ADDR_W, LINES, WORDS);

  dc_state_e        state_r, state_s;
  logic [OFF_W-1:0] cnt_r;
  logic [IDX_W-1:0] miss_index_r;
  logic [TAG_W-1:0] miss_tag_r;

  logic [OFF_W-1:0] cpu_offset_s;
  logic [IDX_W-1:0] cpu_index_s;
  logic [TAG_W-1:0] cpu_tag_s;
  logic             addr_lsb_unused_s;
  logic [31:0]      lk_data_s, mx_data_s;
  logic [TAG_W-1:0] lk_tag_s, mx_tag_s;
  logic             lk_valid_s, lk_dirty_s;
  logic             hit_s, req_s, last_s, miss_s;
  logic             wr_en_s, wr_dirty_s, meta_en_s;
  logic [IDX_W-1:0] wr_index_s;
  logic [OFF_W-1:0] wr_offset_s;
  logic [31:0]      wr_data_s;

  assign cpu_offset_s      = cpu_addr[OFF_W+1:2];
  assign cpu_index_s       = cpu_addr[OFF_W+2 +: IDX_W];
  assign cpu_tag_s         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign addr_lsb_unused_s = ^cpu_addr[1:0];

  assign req_s     = cpu_rd | cpu_wr;
  assign hit_s     = lk_valid_s & (lk_tag_s == cpu_tag_s);
  assign miss_s    = (state_r == ST_IDLE) & req_s & ~hit_s;
  assign last_s    = (cnt_r == OFF_W'(WORDS - 1));
  assign cpu_stall = req_s & ((state_r != ST_IDLE) | ~hit_s);
  assign cpu_rdata = hit_s ? lk_data_s : 32'd0;
  assign meta_en_s = (state_r == ST_FILL) & mem_ack & last_s;

  dcache_line_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .TAG_W (TAG_W)
  ) u_store (
    .clock     (clock),
    .reset     (reset),
    .lk_index  (cpu_index_s),
    .lk_offset (cpu_offset_s),
    .lk_data   (lk_data_s),
    .lk_tag    (lk_tag_s),
    .lk_valid  (lk_valid_s),
    .lk_dirty  (lk_dirty_s),
    .mx_index  (miss_index_r),
    .mx_offset (cnt_r),
    .mx_data   (mx_data_s),
    .mx_tag    (mx_tag_s),
    .wr_en     (wr_en_s),
    .wr_dirty  (wr_dirty_s),
    .wr_index  (wr_index_s),
    .wr_offset (wr_offset_s),
    .wr_data   (wr_data_s),
    .meta_en   (meta_en_s),
    .meta_tag  (miss_tag_r)
  );

  // Next-state: evict first only when the victim line is valid and dirty
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) state_s = (lk_valid_s && lk_dirty_s) ? ST_WB : ST_FILL;
        else        state_s = ST_IDLE;
      end
      ST_WB: begin
        if (mem_ack && last_s) state_s = ST_FILL;
        else                   state_s = ST_WB;
      end
      ST_FILL: begin
        if (mem_ack && last_s) state_s = ST_IDLE;
        else                   state_s = ST_FILL;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, word counter and the captured miss address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      miss_index_r <= '0;
      miss_tag_r   <= '0;
    end else begin
      state_r <= state_s;
      // Counter reaches WORDS-1 on the last word, so the increment wraps to 0
      if (state_r != ST_IDLE && mem_ack) cnt_r <= cnt_r + OFF_W'(1);
      if (miss_s) begin
        miss_index_r <= cpu_index_s;
        miss_tag_r   <= cpu_tag_s;
      end
    end
  end

  // Single array write port: refill words take priority over CPU store hits
  always_comb begin
    wr_en_s     = 1'b0;
    wr_dirty_s  = 1'b0;
    wr_index_s  = '0;
    wr_offset_s = '0;
    wr_data_s   = 32'd0;
    if (state_r == ST_FILL && mem_ack) begin
      wr_en_s     = 1'b1;
      wr_index_s  = miss_index_r;
      wr_offset_s = cnt_r;
      wr_data_s   = mem_rdata;
    end else if (state_r == ST_IDLE && cpu_wr && hit_s) begin
      wr_en_s     = 1'b1;
      wr_dirty_s  = 1'b1;
      wr_index_s  = cpu_index_s;
      wr_offset_s = cpu_offset_s;
      wr_data_s   = cpu_wdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Memory-side handshake; all fields are functions of registered state
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'd0;
    case (state_r)
      ST_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {mx_tag_s, miss_index_r, cnt_r, 2'b00};
        mem_wdata = mx_data_s;
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_r, miss_index_r, cnt_r, 2'b00};
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        refilled_r;
  logic [31:0] hits_r, misses_r, wbacks_r;

  // The completing cycle right after a refill belongs to the miss, not a hit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      refilled_r <= 1'b0;
      hits_r     <= 32'd0;
      misses_r   <= 32'd0;
      wbacks_r   <= 32'd0;
    end else begin
      refilled_r <= meta_en_s;
      if (req_s && !cpu_stall && !refilled_r && hits_r != 32'hFFFF_FFFF)
        hits_r <= hits_r + 32'd1;
      if (miss_s && misses_r != 32'hFFFF_FFFF)
        misses_r <= misses_r + 32'd1;
      if (miss_s && state_s == ST_WB && wbacks_r != 32'hFFFF_FFFF)
        wbacks_r <= wbacks_r + 32'd1;
    end
  end

  assign stat_hits   = hits_r;
  assign stat_misses = misses_r;
  assign stat_wbacks = wbacks_r;
`endif

endmodule
